// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters (port 0 and
// port 1). A request is accepted only in IDLE. Its operands are latched and
// driven to the ALU for one EXEC cycle. The result is then held in the
// owner's response registers until the owner consumes it in RESP.
//
// Timing: a request accepted in cycle T has its response valid from T+2. The
// minimum issue interval is three cycles.
//
// Opcodes at or above NUM_OPS are illegal. They are still issued to the ALU.
// Their response carries out=0, zero=alu_zero and err=1.
//
// Configuration macro:
//   ALU_ARB_RR_EN   defined   : round-robin between the ports when both
//                               request in the same cycle. After reset,
//                               port 0 wins the first contention.
//                   undefined : fixed priority. Port 0 always beats port 1,
//                               and no pointer state exists.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   rN_valid / rN_ready       request handshake (ready is combinational)
//   rN_op, rN_src1, rN_src2   ALU opcode and operands
//   rN_invert                 zero-flag invert (bne-style compare)
//   rN_rsp_valid/rN_rsp_ready response handshake
//   rN_rsp_out/zero/err       registered response data
//   alu_operation/src1/src2/invert  registered drive to the shared ALU
//   alu_out, alu_zero         combinational result from the shared ALU
//   busy                      high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NUM_OPS = 10
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [3:0]  r0_op,
    input  logic [31:0] r0_src1,
    input  logic [31:0] r0_src2,
    input  logic        r0_invert,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic [31:0] r0_rsp_out,
    output logic        r0_rsp_zero,
    output logic        r0_rsp_err,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [3:0]  r1_op,
    input  logic [31:0] r1_src1,
    input  logic [31:0] r1_src2,
    input  logic        r1_invert,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [31:0] r1_rsp_out,
    output logic        r1_rsp_zero,
    output logic        r1_rsp_err,

    output logic [3:0]  alu_operation,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic        alu_invert,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] NUM_OPS_U = NUM_OPS;

    state_t      state_r;
    state_t      state_next;

    logic        owner_r;
    logic [3:0]  op_r;
    logic [31:0] src1_r;
    logic [31:0] src2_r;
    logic        invert_r;

    logic [1:0]  rsp_valid_r;
    logic [31:0] rsp_out_r [2];
    logic [1:0]  rsp_zero_r;
    logic [1:0]  rsp_err_r;

    logic        grant0_s;
    logic        grant1_s;
    logic        accept_s;
    logic        owner_rsp_ready_s;
    logic        illegal_op_s;

`ifdef ALU_ARB_RR_EN
    // 1 means port 1 was granted last, so port 0 wins the next contention.
    logic        last_grant_r;
`endif

    // Grant selection; computed every cycle, only honoured in IDLE.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
`ifdef ALU_ARB_RR_EN
        if (r0_valid && r1_valid) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = r0_valid;
            grant1_s = r1_valid;
        end
`else
        grant0_s = r0_valid;
        grant1_s = r1_valid & ~r0_valid;
`endif
    end

    assign accept_s          = (state_r == IDLE) && (grant0_s || grant1_s);
    assign owner_rsp_ready_s = owner_r ? r1_rsp_ready : r0_rsp_ready;
    assign illegal_op_s      = ({28'd0, op_r} >= NUM_OPS_U);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_next = EXEC;
                end else begin
                    state_next = IDLE;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (owner_rsp_ready_s) begin
                    state_next = IDLE;
                end else begin
                    state_next = RESP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: request ready depends only on state, grant and valid.
    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        busy     = 1'b1;
        case (state_r)
            IDLE: begin
                r0_ready = grant0_s;
                r1_ready = grant1_s;
                busy     = 1'b0;
            end
            EXEC: begin
                busy = 1'b1;
            end
            RESP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Request latch; also the ALU drive registers, held outside acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r  <= 1'b0;
            op_r     <= 4'd0;
            src1_r   <= 32'd0;
            src2_r   <= 32'd0;
            invert_r <= 1'b0;
        end else if (accept_s) begin
            owner_r <= grant1_s;
            if (grant1_s) begin
                op_r     <= r1_op;
                src1_r   <= r1_src1;
                src2_r   <= r1_src2;
                invert_r <= r1_invert;
            end else begin
                op_r     <= r0_op;
                src1_r   <= r0_src1;
                src2_r   <= r0_src2;
                invert_r <= r0_invert;
            end
        end
    end

`ifdef ALU_ARB_RR_EN
    // Round-robin pointer; records the port granted on every acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= grant1_s;
        end
    end
`endif

    // Response registers: captured in EXEC, valid cleared on the owner handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r  <= 2'b00;
            rsp_out_r[0] <= 32'd0;
            rsp_out_r[1] <= 32'd0;
            rsp_zero_r   <= 2'b00;
            rsp_err_r    <= 2'b00;
        end else begin
            case (state_r)
                EXEC: begin
                    rsp_valid_r[owner_r] <= 1'b1;
                    rsp_out_r[owner_r]   <= illegal_op_s ? 32'd0 : alu_out;
                    rsp_zero_r[owner_r]  <= alu_zero;
                    rsp_err_r[owner_r]   <= illegal_op_s;
                end
                RESP: begin
                    if (owner_rsp_ready_s) begin
                        rsp_valid_r[owner_r] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_operation = op_r;
    assign alu_src1      = src1_r;
    assign alu_src2      = src2_r;
    assign alu_invert    = invert_r;

    assign r0_rsp_valid  = rsp_valid_r[0];
    assign r0_rsp_out    = rsp_out_r[0];
    assign r0_rsp_zero   = rsp_zero_r[0];
    assign r0_rsp_err    = rsp_err_r[0];
    assign r1_rsp_valid  = rsp_valid_r[1];
    assign r1_rsp_out    = rsp_out_r[1];
    assign r1_rsp_zero   = rsp_zero_r[1];
    assign r1_rsp_err    = rsp_err_r[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. It provides the shared ALU itself
// (combinational, driven from the arbiter's ALU ports). A transaction-level
// reference model runs alongside and is checked every cycle against all
// outputs. The model tracks one outstanding request, its age in cycles, and
// the last response per port.
//
// On top of the model there are:
//   - a directed vector table,
//   - hand sequences for response back-pressure, reset in EXEC and
//     contention,
//   - a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int TB_NUM_OPS = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_invert, r0_rsp_valid, r0_rsp_ready, r0_rsp_zero, r0_rsp_err;
    logic [3:0]  r0_op;
    logic [31:0] r0_src1, r0_src2, r0_rsp_out;
    logic        r1_valid, r1_ready, r1_invert, r1_rsp_valid, r1_rsp_ready, r1_rsp_zero, r1_rsp_err;
    logic [3:0]  r1_op;
    logic [31:0] r1_src1, r1_src2, r1_rsp_out;
    logic [3:0]  alu_operation;
    logic [31:0] alu_src1, alu_src2, alu_out;
    logic        alu_invert, alu_zero, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_OPS(TB_NUM_OPS)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_src1(r0_src1),
        .r0_src2(r0_src2), .r0_invert(r0_invert), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_rsp_out(r0_rsp_out), .r0_rsp_zero(r0_rsp_zero),
        .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_src1(r1_src1),
        .r1_src2(r1_src2), .r1_invert(r1_invert), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_rsp_out(r1_rsp_out), .r1_rsp_zero(r1_rsp_zero),
        .r1_rsp_err(r1_rsp_err),
        .alu_operation(alu_operation), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_invert(alu_invert), .alu_out(alu_out), .alu_zero(alu_zero),
        .busy(busy)
    );

    // The shared ALU. Illegal opcodes still produce a value, so that the
    // arbiter's masking of the result is observable.
    function automatic logic [31:0] alu_raw(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return {31'd0, $signed(a) < $signed(b)};
            4'd8:    return {31'd0, a < b};
            4'd9:    return $unsigned($signed(a) >>> b[4:0]);
            default: return a + 32'd1;
        endcase
    endfunction

    assign alu_out  = alu_raw(alu_operation, alu_src1, alu_src2);
    assign alu_zero = (alu_out == 32'd0) ^ alu_invert;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          live = 1'b0;
    bit          m_pend = 1'b0;
    int          m_owner = 0;
    int          m_age = 0;
    int          m_last = 1;
    logic [31:0] m_out;
    logic        m_zero, m_err;
    logic [31:0] h_out [2];
    logic        h_zero [2];
    logic        h_err [2];
    logic [3:0]  m_aop;
    logic [31:0] m_as1, m_as2;
    logic        m_ainv;

    function automatic int exp_grant();
        if (m_pend) return -1;
        if (r0_valid && r1_valid) begin
`ifdef ALU_ARB_RR_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (r0_valid) return 0;
        if (r1_valid) return 1;
        return -1;
    endfunction

    // Check this cycle's outputs against the model, then advance the model
    // with this cycle's (stable) inputs.
    always @(negedge clk) begin
        int          g;
        logic        rdy;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        inv;
        g = exp_grant();
        if (live) begin
            check("r0_ready", r0_ready, g == 0);
            check("r1_ready", r1_ready, g == 1);
            check("busy", busy, m_pend);
            check("r0_rsp_valid", r0_rsp_valid, m_pend && m_age >= 2 && m_owner == 0);
            check("r1_rsp_valid", r1_rsp_valid, m_pend && m_age >= 2 && m_owner == 1);
            check("r0_rsp_out", r0_rsp_out, h_out[0]);
            check("r0_rsp_zero", r0_rsp_zero, h_zero[0]);
            check("r0_rsp_err", r0_rsp_err, h_err[0]);
            check("r1_rsp_out", r1_rsp_out, h_out[1]);
            check("r1_rsp_zero", r1_rsp_zero, h_zero[1]);
            check("r1_rsp_err", r1_rsp_err, h_err[1]);
            check("alu_operation", alu_operation, m_aop);
            check("alu_src1", alu_src1, m_as1);
            check("alu_src2", alu_src2, m_as2);
            check("alu_invert", alu_invert, m_ainv);
        end
        if (rst) begin
            live   = 1'b1;
            m_pend = 1'b0;
            m_last = 1;
            for (int i = 0; i < 2; i++) begin
                h_out[i] = 32'd0; h_zero[i] = 1'b0; h_err[i] = 1'b0;
            end
            m_aop = 4'd0; m_as1 = 32'd0; m_as2 = 32'd0; m_ainv = 1'b0;
        end else if (m_pend) begin
            if (m_age >= 2) begin
                rdy = (m_owner == 0) ? r0_rsp_ready : r1_rsp_ready;
                if (rdy) m_pend = 1'b0;
            end else begin
                m_age = 2;
                h_out[m_owner]  = m_out;
                h_zero[m_owner] = m_zero;
                h_err[m_owner]  = m_err;
            end
        end else if (g >= 0) begin
            op  = (g == 0) ? r0_op : r1_op;
            a   = (g == 0) ? r0_src1 : r1_src1;
            b   = (g == 0) ? r0_src2 : r1_src2;
            inv = (g == 0) ? r0_invert : r1_invert;
            m_aop = op; m_as1 = a; m_as2 = b; m_ainv = inv;
            m_err  = (int'(op) >= TB_NUM_OPS);
            m_out  = m_err ? 32'd0 : alu_raw(op, a, b);
            m_zero = (alu_raw(op, a, b) == 32'd0) ^ inv;
            m_pend = 1'b1;
            m_age  = 1;
            m_owner = g;
            m_last  = g;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        r0_valid = 1'b0; r0_op = 4'd0; r0_src1 = 32'd0; r0_src2 = 32'd0; r0_invert = 1'b0; r0_rsp_ready = 1'b1;
        r1_valid = 1'b0; r1_op = 4'd0; r1_src1 = 32'd0; r1_src2 = 32'd0; r1_invert = 1'b0; r1_rsp_ready = 1'b1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic inv);
        if (p == 0) begin
            r0_valid = v; r0_op = op; r0_src1 = a; r0_src2 = b; r0_invert = inv;
        end else begin
            r1_valid = v; r1_op = op; r1_src1 = a; r1_src2 = b; r1_invert = inv;
        end
    endtask

    // Issue one request, wait for acceptance and the response; lat counts
    // cycles from the acceptance cycle to the first rsp_valid cycle.
    task automatic do_txn(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic inv, output logic [31:0] out, output logic z, output logic e,
                          output int lat);
        bit got;
        @(posedge clk); #1;
        set_req(p, 1'b1, op, a, b, inv);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? r0_ready : r1_ready;
        end
        check("txn accept", got, 1'b1);
        @(posedge clk); #1;
        set_req(p, 1'b0, op, a, b, inv);
        got = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? r0_rsp_valid : r1_rsp_valid;
            if (got) lat = k;
        end
        check("txn response", got, 1'b1);
        out = (p == 0) ? r0_rsp_out : r1_rsp_out;
        z   = (p == 0) ? r0_rsp_zero : r1_rsp_zero;
        e   = (p == 0) ? r0_rsp_err : r1_rsp_err;
    endtask

    typedef struct {
        int          p;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        inv;
        logic [31:0] eo;
        logic        ez;
        logic        ee;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [13];
        logic [31:0] o;
        logic        z, e;
        int          lat;
        int          q[$];
        bit          got;

        vecs[0]  = '{0, 4'd2,  32'd5,          32'd7,          1'b0, 32'd12,         1'b0, 1'b0};
        vecs[1]  = '{1, 4'd3,  32'd9,          32'd9,          1'b1, 32'd0,          1'b0, 1'b0};
        vecs[2]  = '{1, 4'd3,  32'd9,          32'd9,          1'b0, 32'd0,          1'b1, 1'b0};
        vecs[3]  = '{0, 4'd12, 32'd5,          32'd3,          1'b0, 32'd0,          1'b0, 1'b1};
        vecs[4]  = '{0, 4'd2,  32'd1,          32'd1,          1'b0, 32'd2,          1'b0, 1'b0};
        vecs[5]  = '{1, 4'd0,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  1'b0, 32'h00F0_00F0,  1'b0, 1'b0};
        vecs[6]  = '{0, 4'd4,  32'hAAAA_5555,  32'hAAAA_5555,  1'b0, 32'd0,          1'b1, 1'b0};
        vecs[7]  = '{1, 4'd5,  32'd1,          32'd31,         1'b0, 32'h8000_0000,  1'b0, 1'b0};
        vecs[8]  = '{0, 4'd7,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd1,          1'b0, 1'b0};
        vecs[9]  = '{1, 4'd15, 32'hFFFF_FFFF,  32'd0,          1'b0, 32'd0,          1'b1, 1'b1};
        vecs[10] = '{0, 4'd10, 32'd0,          32'd0,          1'b0, 32'd0,          1'b0, 1'b1};
        vecs[11] = '{1, 4'd9,  32'h8000_0000,  32'd4,          1'b0, 32'hF800_0000,  1'b0, 1'b0};
        vecs[12] = '{0, 4'd8,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b1, 1'b0};

        // Reset.
        rst = 1'b1;
        set_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset r0_rsp_valid", r0_rsp_valid, 1'b0);
        check("reset r1_rsp_valid", r1_rsp_valid, 1'b0);
        check("reset r0_rsp_out", r0_rsp_out, 32'd0);
        check("reset r1_rsp_err", r1_rsp_err, 1'b0);
        check("reset alu_operation", alu_operation, 4'd0);
        check("reset alu_src1", alu_src1, 32'd0);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            do_txn(vecs[i].p, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inv, o, z, e, lat);
            check($sformatf("vec%0d out", i), o, vecs[i].eo);
            check($sformatf("vec%0d zero", i), z, vecs[i].ez);
            check($sformatf("vec%0d err", i), e, vecs[i].ee);
            check($sformatf("vec%0d latency", i), lat, 32'd2);
        end

        // Response back-pressure: SRA result held for 5 cycles, no new accept.
        @(posedge clk); #1;
        r0_rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd9, 32'h8000_0000, 32'd4, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = r0_ready;
        end
        check("hold accept", got, 1'b1);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = r0_rsp_valid;
        end
        check("hold rsp_valid", got, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold rsp_valid held", r0_rsp_valid, 1'b1);
            check("hold rsp_out", r0_rsp_out, 32'hF800_0000);
            check("hold r0_ready low", r0_ready, 1'b0);
        end
        @(posedge clk); #1;
        r0_rsp_ready = 1'b1;
        r0_valid = 1'b0;
        @(negedge clk);
        check("hold handshake cycle", r0_rsp_valid, 1'b1);
        @(negedge clk);
        check("hold released valid", r0_rsp_valid, 1'b0);
        check("hold released busy", busy, 1'b0);
        check("hold out retained", r0_rsp_out, 32'hF800_0000);

        // Reset during EXEC, then contention with both ports valid.
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd2, 32'd3, 32'd4, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = r0_ready;
        end
        check("rst accept", got, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("rst busy", busy, 1'b0);
                check("rst r0_rsp_valid", r0_rsp_valid, 1'b0);
                check("rst r1_rsp_valid", r1_rsp_valid, 1'b0);
                check("rst r0_rsp_out cleared", r0_rsp_out, 32'd0);
                check("rst first grant r0", r0_ready, 1'b1);
                check("rst first grant r1", r1_ready, 1'b0);
            end
            if (r0_ready) q.push_back(0);
            if (r1_ready) q.push_back(1);
        end
        check("contention grant count", q.size(), 32'd4);
        for (int i = 0; i < 4 && i < q.size(); i++) begin
`ifdef ALU_ARB_RR_EN
            check($sformatf("contention grant%0d", i), q[i], i % 2);
`else
            check($sformatf("contention grant%0d", i), q[i], 32'd0);
`endif
        end

        // Randomized phase; the model checks every cycle.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 79) == 0);
            r0_valid     = 1'($urandom_range(0, 1));
            r0_op        = 4'($urandom_range(0, 15));
            r0_src1      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            r0_src2      = ($urandom_range(0, 2) == 0) ? r0_src1 : $urandom();
            r0_invert    = 1'($urandom_range(0, 1));
            r0_rsp_ready = ($urandom_range(0, 3) != 0);
            r1_valid     = 1'($urandom_range(0, 1));
            r1_op        = 4'($urandom_range(0, 15));
            r1_src1      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            r1_src2      = ($urandom_range(0, 2) == 0) ? r1_src1 : $urandom();
            r1_invert    = 1'($urandom_range(0, 1));
            r1_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drain busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NUM_OPS, default 10; opcodes >= NUM_OPS are illegal.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports rN_valid  input  1  request valid, for N=0,1.
REQ-005 SHALL have ports rN_ready  output  1  request accepted this cycle, for N=0,1.
REQ-006 SHALL have ports rN_op  input  4  ALU operation code, for N=0,1.
REQ-007 SHALL have ports rN_src1, rN_src2  input  32  operands, for N=0,1.
REQ-008 SHALL have ports rN_invert  input  1  zero-flag invert (bne), for N=0,1.
REQ-009 SHALL have ports rN_rsp_valid  output  1  result valid, for N=0,1.
REQ-010 SHALL have ports rN_rsp_ready  input  1  result consumed, for N=0,1.
REQ-011 SHALL have ports rN_rsp_out  output  32, rN_rsp_zero  output  1, rN_rsp_err  output  1, for N=0,1.
REQ-012 SHALL have ports alu_operation  output  4, alu_src1/alu_src2  output  32, alu_invert  output  1  drive to the shared ALU.
REQ-013 SHALL have ports alu_out  input  32, alu_zero  input  1  combinational result from the shared ALU.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 IDLE: if any rN_valid, SHALL assert rN_ready for exactly one granted port that cycle, latch its op/src1/src2/invert and owner, go to EXEC.
REQ-017 rN_ready SHALL be low in EXEC and RESP; requests are accepted only in IDLE.
REQ-018 ALU drive ports SHALL come directly from the latch registers and hold their value outside EXEC.
REQ-019 EXEC: SHALL capture alu_out and alu_zero into the owner's response registers; go to RESP after exactly one cycle.
REQ-020 Illegal op (op >= NUM_OPS): SHALL still issue the op to the ALU, capture rsp_out=0, rsp_zero=alu_zero, rsp_err=1; otherwise rsp_err=0.
REQ-021 RESP: SHALL hold owner rsp_valid high with stable rsp_out/zero/err until owner rsp_ready is high; then go to IDLE.
REQ-022 Non-owner rsp_valid SHALL stay low; rsp_ready from a non-owner SHALL be ignored.
REQ-023 Latency: acceptance in cycle T SHALL give rsp_valid high from cycle T+2; minimum issue interval is 3 cycles.
REQ-024 rN_ready SHALL depend combinationally only on state, grant logic and rN_valid, never on rsp_ready.
REQ-025 Response registers SHALL hold their last value after the handshake; only rsp_valid clears.

Reset
REQ-026 On rst high at a clock edge: state=IDLE; all rsp_valid=0; rsp_out=0, rsp_zero=0, rsp_err=0; ALU drive registers=0; round-robin pointer set so port 0 wins first.
REQ-027 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight result with no rsp_valid pulse; rst SHALL override simultaneous valid/ready.

Configuration
REQ-028 ALU_ARB_RR_EN defined: when both valid in IDLE, SHALL grant the port not granted last; pointer updates on each acceptance.
REQ-029 ALU_ARB_RR_EN undefined: SHALL use fixed priority, port 0 always beating port 1; no pointer state.

Verification
REQ-030 r0 ADD op=2, 5+7, both rsp_ready=1 -> r0_ready pulse T, r0_rsp_valid at T+2, out=12, zero=0, err=0.
REQ-031 r1 SUB op=3, 9-9, invert=1 -> r1_rsp_out=0, r1_rsp_zero=0; with invert=0 -> zero=1.
REQ-032 Both valid continuously, RR on -> grants alternate 0,1,0,1; RR off -> port 0 every grant, port 1 starved.
REQ-033 r0 SRA op=9, src1=0x80000000, src2=4, r0_rsp_ready held low 5 cycles -> rsp_valid held, out=0xF8000000 stable, r0_ready low throughout.
REQ-034 r0 op=12 -> rsp_err=1, rsp_out=0; next legal op -> err=0.
REQ-035 rst asserted in EXEC -> next cycle IDLE, busy=0, no rsp_valid, then first grant goes to port 0.
